rv_lsu: RTL and testbench

//  Memory stage load/store unit for the rv pipeline. It sits between execute and writeback.

---
 rtl/rv_lsu.sv | 220 ++++++++++++++++++++++
 tb/tb_rv_lsu.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_lsu.sv
// Memory-stage load/store unit: steers byte lanes, checks alignment, retires into a writeback register.
// Latency 1 (plus bus wait states); stall_out holds upstream while an access is outstanding, stall_in freezes the writeback register.
module rv_lsu #(
    parameter int XLEN = 32,
    localparam int LANES = XLEN / 8,
    localparam int LB = $clog2(LANES)
) (
    input  logic             clk,
    input  logic             reset_,
    input  logic             stall_in,
    input  logic             flush_in,
    input  logic             valid_in,
    input  logic             read_in,
    input  logic             write_in,
    input  logic [1:0]       width_in,
    input  logic             zero_extend_in,
    input  logic [4:0]       rd_in,
    input  logic             rd_write_in,
    input  logic [XLEN-1:0]  result_in,
    input  logic [XLEN-1:0]  rs2_value_in,
    output logic             data_req_out,
    output logic             data_we_out,
    output logic [XLEN-1:0]  data_address_out,
    output logic [XLEN-1:0]  data_write_value_out,
    output logic [LANES-1:0] data_write_mask_out,
    input  logic             data_ready_in,
    input  logic [XLEN-1:0]  data_read_value_in,
    output logic             stall_out,
    output logic             valid_out,
    output logic [4:0]       rd_out,
    output logic             rd_write_out,
    output logic [XLEN-1:0]  rd_value_out,
    output logic             fault_out
);

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    state_t          state_q, state_d;
    logic            kill_q, kill_d, kill_eff;
    logic [XLEN-1:0] hold_q;

    logic             is_mem, bad_width, misalign, fault_op, go;
    logic [2:0]       alo;
    logic [LB-1:0]    lane;
    logic [LANES-1:0] base_mask, lane_mask;
    logic [XLEN-1:0]  wr_rep, rd_shift, field_mask, load_val, mem_val;
    logic             sign_bit;

    logic            req, busy, hold_en, wb_en, wb_valid, wb_write, wb_fault;
    logic [XLEN-1:0] wb_value;
    logic            live;

    assign alo       = result_in[2:0];
    assign lane      = result_in[LB-1:0];
    assign is_mem    = valid_in && (read_in || write_in);
    assign bad_width = (width_in == 2'b11) && (XLEN == 32);
    assign fault_op  = is_mem && (bad_width || misalign);
    assign go        = is_mem && !fault_op && !flush_in && !stall_in;
    assign kill_eff  = kill_q || flush_in;

    always_comb begin
        case (width_in)
            2'b01:   misalign = alo[0];
            2'b00:   misalign = |alo[1:0];
            2'b11:   misalign = |alo;
            default: misalign = 1'b0;
        endcase
    end

    // Unshifted byte-enable pattern for the access size; doubles as the load field mask.
    always_comb begin
        case (width_in)
            2'b10:   base_mask = LANES'(1);
            2'b01:   base_mask = LANES'(3);
            2'b00:   base_mask = LANES'(15);
            default: base_mask = '1;
        endcase
    end

    assign lane_mask = base_mask << lane;

    always_comb begin
        case (width_in)
            2'b10:   wr_rep = {LANES{rs2_value_in[7:0]}};
            2'b01:   wr_rep = {(LANES/2){rs2_value_in[15:0]}};
            2'b00:   wr_rep = {(LANES/4){rs2_value_in[31:0]}};
            default: wr_rep = rs2_value_in;
        endcase
    end

    assign rd_shift = data_read_value_in >> {lane, 3'b000};

    always_comb begin
        field_mask = '0;
        for (int i = 0; i < LANES; i++) begin
            field_mask[8*i +: 8] = {8{base_mask[i]}};
        end
    end

    always_comb begin
        case (width_in)
            2'b10:   sign_bit = rd_shift[7];
            2'b01:   sign_bit = rd_shift[15];
            2'b00:   sign_bit = rd_shift[31];
            default: sign_bit = rd_shift[XLEN-1];
        endcase
    end

    assign load_val = (rd_shift & field_mask)
                    | ({XLEN{!zero_extend_in && sign_bit}} & ~field_mask);
    assign mem_val  = read_in ? load_val : result_in;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q <= IDLE;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            kill_q  <= kill_d;
        end
    end

    always_comb begin
        state_d = state_q;
        kill_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (go && !data_ready_in) state_d = WAIT;
            end
            WAIT: begin
                kill_d = kill_eff;
                if (data_ready_in) state_d = stall_in ? HOLD : IDLE;
            end
            HOLD: begin
                kill_d = kill_eff;
                if (!stall_in) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (state_d == IDLE) kill_d = 1'b0;
    end

    // A cycle that retires nothing loads a bubble, so valid_out never repeats an instruction.
    always_comb begin
        req      = 1'b0;
        busy     = 1'b0;
        hold_en  = 1'b0;
        wb_en    = !stall_in;
        wb_valid = 1'b0;
        wb_write = 1'b0;
        wb_fault = 1'b0;
        wb_value = result_in;
        case (state_q)
            IDLE: begin
                req  = go;
                busy = go && !data_ready_in;
                if (fault_op) begin
                    wb_valid = !flush_in;
                    wb_fault = !flush_in;
                end else if (go) begin
                    if (data_ready_in) begin
                        wb_valid = 1'b1;
                        wb_write = rd_write_in;
                        wb_value = mem_val;
                    end
                end else if (!is_mem) begin
                    wb_valid = valid_in && !flush_in;
                    wb_write = rd_write_in && valid_in && !flush_in;
                end
            end
            WAIT: begin
                req     = 1'b1;
                busy    = !(data_ready_in && !stall_in);
                hold_en = data_ready_in && stall_in;
                if (data_ready_in) begin
                    wb_valid = !kill_eff;
                    wb_write = rd_write_in && !kill_eff;
                    wb_value = mem_val;
                end
            end
            HOLD: begin
                busy     = 1'b1;
                wb_valid = !kill_eff;
                wb_write = rd_write_in && !kill_eff;
                wb_value = hold_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            valid_out    <= 1'b0;
            rd_out       <= '0;
            rd_write_out <= 1'b0;
            rd_value_out <= '0;
            fault_out    <= 1'b0;
            hold_q       <= '0;
        end else begin
            if (wb_en) begin
                valid_out    <= wb_valid;
                rd_out       <= rd_in;
                rd_write_out <= wb_write;
                rd_value_out <= wb_value;
                fault_out    <= wb_fault;
            end
            if (hold_en) hold_q <= mem_val;
        end
    end

    // Bus outputs are gated by reset so an abandoned request drops without a clock edge.
    assign live                 = req && reset_;
    assign data_req_out         = live;
    assign data_we_out          = live && write_in;
    assign data_address_out     = live ? {result_in[XLEN-1:LB], {LB{1'b0}}} : '0;
    assign data_write_value_out = live ? wr_rep : '0;
    assign data_write_mask_out  = (live && write_in) ? lane_mask : '0;
    assign stall_out            = busy && reset_;

endmodule

// File: tb/tb_rv_lsu.sv
// Directed and randomized checks of rv_lsu at XLEN=32 and XLEN=64 against an arithmetic model.
module tb_rv_lsu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_, stall_in, flush_in, v32, v64, read_in, write_in;
    logic        zero_extend_in, rd_write_in, data_ready_in;
    logic [1:0]  width_in;
    logic [4:0]  rd_in;
    logic [63:0] result_in, rs2_value_in, data_read_value_in;

    logic        o32_req, o32_we, o32_stall, o32_valid, o32_rdw, o32_fault;
    logic [31:0] o32_addr, o32_wval, o32_rdv;
    logic [3:0]  o32_mask;
    logic [4:0]  o32_rd;
    logic        o64_req, o64_we, o64_stall, o64_valid, o64_rdw, o64_fault;
    logic [63:0] o64_addr, o64_wval, o64_rdv;
    logic [7:0]  o64_mask;
    logic [4:0]  o64_rd;

    rv_lsu #(.XLEN(32)) u32 (
        .clk(clk), .reset_(reset_), .stall_in(stall_in), .flush_in(flush_in),
        .valid_in(v32), .read_in(read_in), .write_in(write_in), .width_in(width_in),
        .zero_extend_in(zero_extend_in), .rd_in(rd_in), .rd_write_in(rd_write_in),
        .result_in(result_in[31:0]), .rs2_value_in(rs2_value_in[31:0]),
        .data_req_out(o32_req), .data_we_out(o32_we), .data_address_out(o32_addr),
        .data_write_value_out(o32_wval), .data_write_mask_out(o32_mask),
        .data_ready_in(data_ready_in), .data_read_value_in(data_read_value_in[31:0]),
        .stall_out(o32_stall), .valid_out(o32_valid), .rd_out(o32_rd),
        .rd_write_out(o32_rdw), .rd_value_out(o32_rdv), .fault_out(o32_fault)
    );

    rv_lsu #(.XLEN(64)) u64 (
        .clk(clk), .reset_(reset_), .stall_in(stall_in), .flush_in(flush_in),
        .valid_in(v64), .read_in(read_in), .write_in(write_in), .width_in(width_in),
        .zero_extend_in(zero_extend_in), .rd_in(rd_in), .rd_write_in(rd_write_in),
        .result_in(result_in), .rs2_value_in(rs2_value_in),
        .data_req_out(o64_req), .data_we_out(o64_we), .data_address_out(o64_addr),
        .data_write_value_out(o64_wval), .data_write_mask_out(o64_mask),
        .data_ready_in(data_ready_in), .data_read_value_in(data_read_value_in),
        .stall_out(o64_stall), .valid_out(o64_valid), .rd_out(o64_rd),
        .rd_write_out(o64_rdw), .rd_value_out(o64_rdv), .fault_out(o64_fault)
    );

    logic        sel64;
    logic        m_req, m_we, m_stall, m_valid, m_rdw, m_fault;
    logic [63:0] m_addr, m_wval, m_rdv;
    logic [7:0]  m_mask;
    logic [4:0]  m_rd;

    always_comb begin
        if (sel64) begin
            m_req = o64_req;  m_we = o64_we;  m_stall = o64_stall; m_valid = o64_valid;
            m_rdw = o64_rdw;  m_fault = o64_fault; m_addr = o64_addr; m_wval = o64_wval;
            m_rdv = o64_rdv;  m_mask = o64_mask; m_rd = o64_rd;
        end else begin
            m_req = o32_req;  m_we = o32_we;  m_stall = o32_stall; m_valid = o32_valid;
            m_rdw = o32_rdw;  m_fault = o32_fault; m_addr = {32'd0, o32_addr};
            m_wval = {32'd0, o32_wval}; m_rdv = {32'd0, o32_rdv};
            m_mask = {4'd0, o32_mask}; m_rd = o32_rd;
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One instruction: op 0 = ALU, 1 = load, 2 = store. Entered and left 1 time unit after a rising edge.
    task automatic txn(input bit x64, input int op, input logic [1:0] w, input bit zx,
                       input logic [63:0] addr, input logic [63:0] rs2, input logic [63:0] rdat,
                       input int waits, input int flush_at, input int hold_cyc, input bit rdw);
        logic [63:0] xm, a, fm, wv, lv, ev, ea;
        int          nb, lanes, lane, em;
        bit          is_ld, is_st, mem, flt, kill;
        logic [4:0]  rd;
        is_ld = (op == 1);
        is_st = (op == 2);
        mem   = is_ld || is_st;
        xm    = x64 ? ~64'd0 : 64'h0000_0000_FFFF_FFFF;
        a     = addr & xm;
        case (w)
            2'b10:   nb = 1;
            2'b01:   nb = 2;
            2'b00:   nb = 4;
            default: nb = 8;
        endcase
        lanes = x64 ? 8 : 4;
        flt   = mem && ((!x64 && w == 2'b11) || (a % 64'(nb)) != 64'd0);
        lane  = int'(a % 64'(lanes));
        ea    = a - 64'(lane);
        em    = ((1 << nb) - 1) << lane;
        fm    = (nb == 8) ? ~64'd0 : ((64'd1 << (8 * nb)) - 64'd1);
        wv    = 64'd0;
        for (int k = 0; k < lanes / nb; k++) wv = wv | ((rs2 & fm) << (8 * nb * k));
        lv = ((rdat & xm) >> (8 * lane)) & fm;
        if (!zx && lv[8*nb-1]) lv = lv | ~fm;
        lv   = lv & xm;
        ev   = is_ld ? lv : a;
        kill = (flush_at >= 1) && (flush_at <= waits);
        rd   = 5'($urandom());

        sel64 = x64; v32 = !x64; v64 = x64;
        read_in = is_ld; write_in = is_st; width_in = w; zero_extend_in = zx;
        rd_in = rd; rd_write_in = rdw; result_in = addr; rs2_value_in = rs2;
        data_read_value_in = rdat; flush_in = 1'b0; stall_in = 1'b0;
        data_ready_in = (waits == 0);

        if (!mem || flt) begin
            #3;
            chk("no_req", 64'(m_req), 64'd0);
            @(posedge clk); #1;
            chk("valid", 64'(m_valid), 64'd1);
            chk("fault", 64'(m_fault), 64'(flt));
            chk("rd_write", 64'(m_rdw), 64'(rdw && !flt));
            chk("rd_value", m_rdv, a);
            chk("rd", 64'(m_rd), 64'(rd));
        end else begin
            for (int c = 0; c <= waits; c++) begin
                data_ready_in = (c == waits);
                flush_in      = (c == flush_at);
                stall_in      = (hold_cyc > 0) && (c == waits);
                #3;
                chk("req", 64'(m_req), 64'd1);
                chk("we", 64'(m_we), 64'(is_st));
                chk("addr", m_addr, ea);
                chk("mask", 64'(m_mask), is_st ? 64'(em) : 64'd0);
                chk("wdata", m_wval, wv);
                chk("stall_out", 64'(m_stall), 64'((c < waits) || stall_in));
                if (c > 0) chk("bubble", 64'(m_valid), 64'd0);
                @(posedge clk); #1;
            end
            flush_in = 1'b0;
            data_ready_in = 1'b0;
            for (int h = 0; h < hold_cyc; h++) begin
                stall_in = (h < hold_cyc - 1);
                data_read_value_in = {$urandom(), $urandom()};
                #3;
                chk("hold_req", 64'(m_req), 64'd0);
                chk("hold_stall", 64'(m_stall), 64'd1);
                @(posedge clk); #1;
            end
            stall_in = 1'b0;
            chk("ret_valid", 64'(m_valid), 64'(!kill));
            chk("ret_rd_write", 64'(m_rdw), 64'(rdw && !kill));
            chk("ret_fault", 64'(m_fault), 64'd0);
            chk("ret_rd", 64'(m_rd), 64'(rd));
            if (!kill) chk("ret_value", m_rdv, ev);
        end
        v32 = 1'b0; v64 = 1'b0; read_in = 1'b0; write_in = 1'b0; data_ready_in = 1'b0;
    endtask

    initial begin
        reset_ = 1'b0; stall_in = 1'b0; flush_in = 1'b0; v32 = 1'b0; v64 = 1'b0;
        read_in = 1'b0; write_in = 1'b0; zero_extend_in = 1'b0; rd_write_in = 1'b0;
        data_ready_in = 1'b0; width_in = 2'b00; rd_in = 5'd0; result_in = 64'd0;
        rs2_value_in = 64'd0; data_read_value_in = 64'd0; sel64 = 1'b0;

        #3;
        chk("rst32_valid", 64'(m_valid), 64'd0);
        chk("rst32_value", m_rdv, 64'd0);
        chk("rst32_req", 64'(m_req), 64'd0);
        sel64 = 1'b1;
        #1;
        chk("rst64_fault", 64'(m_fault), 64'd0);
        chk("rst64_stall", 64'(m_stall), 64'd0);
        @(negedge clk);
        reset_ = 1'b1;
        @(posedge clk); #1;

        // lb with sign extension, bus ready in the request cycle
        txn(1'b0, 1, 2'b10, 1'b0, 64'h1003, 64'd0, 64'h80FF_0000, 0, -1, 0, 1'b1);
        // sh with three wait states
        txn(1'b0, 2, 2'b01, 1'b0, 64'h2002, 64'h1234, 64'd0, 3, -1, 0, 1'b0);
        // lwu on the 64-bit unit from the upper word
        txn(1'b1, 1, 2'b00, 1'b1, 64'h8000_0000_0000_1004, 64'd0, 64'hDEAD_BEEF_0000_0001, 1, -1, 0, 1'b1);
        // misaligned lw faults
        txn(1'b0, 1, 2'b00, 1'b0, 64'h1002, 64'd0, 64'd0, 0, -1, 0, 1'b1);
        // double on the 32-bit unit is illegal
        txn(1'b0, 1, 2'b11, 1'b0, 64'h1008, 64'd0, 64'd0, 0, -1, 0, 1'b1);
        // flush while waiting kills the retirement
        txn(1'b0, 1, 2'b00, 1'b0, 64'h3000, 64'd0, 64'h1111_2222, 2, 1, 0, 1'b1);
        // ready under stall_in goes through the hold register
        txn(1'b0, 1, 2'b00, 1'b0, 64'h3004, 64'd0, 64'hCAFE_F00D, 1, -1, 3, 1'b1);

        // stall_in with nothing pending freezes the register and issues nothing
        txn(1'b0, 0, 2'b00, 1'b0, 64'h55, 64'd0, 64'd0, 0, -1, 0, 1'b1);
        v32 = 1'b1; read_in = 1'b1; width_in = 2'b00; result_in = 64'h4000;
        stall_in = 1'b1; data_ready_in = 1'b1;
        #3;
        chk("idle_stall_req", 64'(m_req), 64'd0);
        chk("idle_stall_out", 64'(m_stall), 64'd0);
        @(posedge clk); #1;
        chk("idle_stall_valid", 64'(m_valid), 64'd1);
        chk("idle_stall_value", m_rdv, 64'h55);
        stall_in = 1'b0; v32 = 1'b0; read_in = 1'b0; data_ready_in = 1'b0;

        for (int i = 0; i < 150; i++) begin
            bit          x, zx, rw;
            int          op, nb, wt, fa, hc;
            logic [1:0]  w;
            logic [63:0] ad;
            x  = 1'($urandom_range(0, 1));
            zx = 1'($urandom_range(0, 1));
            rw = 1'($urandom_range(0, 1));
            op = int'($urandom_range(0, 2));
            w  = 2'($urandom_range(0, 3));
            nb = (w == 2'b10) ? 1 : (w == 2'b01) ? 2 : (w == 2'b00) ? 4 : 8;
            ad = {$urandom(), $urandom()};
            if ($urandom_range(0, 3) != 0) ad = ad & ~64'(nb - 1);
            wt = int'($urandom_range(0, 3));
            fa = -1;
            if (wt > 0 && $urandom_range(0, 3) == 0) fa = int'($urandom_range(1, wt));
            hc = 0;
            if (wt > 0 && $urandom_range(0, 2) == 0) hc = int'($urandom_range(1, 3));
            txn(x, op, w, zx, ad, {$urandom(), $urandom()}, {$urandom(), $urandom()}, wt, fa, hc, rw);
        end

        // reset while a request is outstanding
        sel64 = 1'b0; v32 = 1'b1; read_in = 1'b1; width_in = 2'b00;
        result_in = 64'h5008; data_ready_in = 1'b0;
        #3;
        chk("pre_rst_req", 64'(m_req), 64'd1);
        @(posedge clk); #1;
        chk("pre_rst_stall", 64'(m_stall), 64'd1);
        #1 reset_ = 1'b0;
        #1;
        chk("rst_wait_req", 64'(m_req), 64'd0);
        chk("rst_wait_stall", 64'(m_stall), 64'd0);
        chk("rst_wait_addr", m_addr, 64'd0);
        chk("rst_wait_wdata", m_wval, 64'd0);
        chk("rst_wait_value", m_rdv, 64'd0);
        chk("rst_wait_valid", 64'(m_valid), 64'd0);
        v32 = 1'b0; read_in = 1'b0;
        @(negedge clk);
        reset_ = 1'b1;
        @(posedge clk); #1;
        txn(1'b0, 0, 2'b00, 1'b0, 64'h77, 64'd0, 64'd0, 0, -1, 0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
